memarbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the single-port `datamemory`, which captures on the falling clock edge. It accepts load/store requests from two requesters (port 0: instruction fetch; port 1: load/store unit). It grants one per access slot and drives the memory's address, enables and write data for exactly one cycle. It then returns read data, acknowledge and an alignment error flag to the granted requester.

---
 rtl/memarb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 26 ++
 rtl/memarbiter.sv | 155 +++++++++++++++
 tb/tb_memarbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Round-robin pointer after reset: port 1 "went last", so port 0 wins the first tie.
  localparam logic LAST_RST = PORT_LS;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: masked ports never win, a tie goes to the port that did not win last.
module rr_pick2
  import memarb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic       valid,
  output logic       pick
);

  logic [1:0] w_elig;

  assign w_elig = req & ~mask;
  assign valid  = |w_elig;

  always_comb begin
    pick = PORT_IF;
    if (w_elig == 2'b11) begin
      pick = ~last;
    end else if (w_elig[1]) begin
      pick = PORT_LS;
    end
  end

endmodule

// File: rtl/memarbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port data memory
// that captures on the falling clock edge; one grant per IDLE/RESP decision slot.
module memarbiter
  import memarb_pkg::*;
#(
  parameter int addresswidth = 32,
  parameter int width        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [addresswidth-1:0] addr0,
  input  logic [addresswidth-1:0] addr1,
  input  logic [width-1:0]        wdata0,
  input  logic [width-1:0]        wdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [width-1:0]        rdata0,
  output logic [width-1:0]        rdata1,
  output logic                    err0,
  output logic                    err1,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_write_en,
  output logic                    mem_read_en,
  output logic [width-1:0]        mem_data_in,
  input  logic [width-1:0]        mem_data_out,
  output logic                    busy
);

  state_t                  r_state;
  logic                    r_last;
  logic                    r_grant;
  logic                    r_we;
  logic                    r_mis;
  logic                    r_ack0;
  logic                    r_ack1;
  logic                    r_err0;
  logic                    r_err1;
  logic                    r_busy;
  logic                    r_wen;
  logic                    r_ren;
  logic [addresswidth-1:0] r_maddr;
  logic [width-1:0]        r_mdin;
  logic [width-1:0]        r_rdata0;
  logic [width-1:0]        r_rdata1;

  logic                    w_valid;
  logic                    w_pick;
  logic [1:0]              w_mask;
  logic                    w_sel_we;
  logic                    w_sel_mis;
  logic [addresswidth-1:0] w_sel_addr;
  logic [width-1:0]        w_sel_wdata;

  // The port being acked still holds req during RESP; keep it out of that slot's arbitration.
  assign w_mask = (r_state == ST_RESP) ? ((r_grant == PORT_LS) ? 2'b10 : 2'b01) : 2'b00;

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (r_last),
    .mask  (w_mask),
    .valid (w_valid),
    .pick  (w_pick)
  );

  assign w_sel_we    = (w_pick == PORT_LS) ? we1    : we0;
  assign w_sel_addr  = (w_pick == PORT_LS) ? addr1  : addr0;
  assign w_sel_wdata = (w_pick == PORT_LS) ? wdata1 : wdata0;
  assign w_sel_mis   = misaligned(w_sel_addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_last   <= LAST_RST;
      r_grant  <= PORT_IF;
      r_we     <= 1'b0;
      r_mis    <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_busy   <= 1'b0;
      r_wen    <= 1'b0;
      r_ren    <= 1'b0;
      r_maddr  <= '0;
      r_mdin   <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      r_wen  <= 1'b0;
      r_ren  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_valid) begin
            r_state <= ST_ACCESS;
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_we    <= w_sel_we;
            r_mis   <= w_sel_mis;
            r_maddr <= w_sel_addr;
            r_mdin  <= w_sel_wdata;
            // A misaligned access walks through ACCESS/RESP without touching memory.
            r_wen   <= w_sel_we & ~w_sel_mis;
            r_ren   <= ~w_sel_we & ~w_sel_mis;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_RESP;
          r_busy  <= 1'b1;
          if (r_grant == PORT_IF) begin
            r_ack0 <= 1'b1;
            r_err0 <= r_mis;
            if (!r_we && !r_mis) begin
              r_rdata0 <= mem_data_out;
            end
          end else begin
            r_ack1 <= 1'b1;
            r_err1 <= r_mis;
            if (!r_we && !r_mis) begin
              r_rdata1 <= mem_data_out;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign err0         = r_err0;
  assign err1         = r_err1;
  assign rdata0       = r_rdata0;
  assign rdata1       = r_rdata1;
  assign busy         = r_busy;
  assign mem_address  = r_maddr;
  assign mem_write_en = r_wen;
  assign mem_read_en  = r_ren;
  assign mem_data_in  = r_mdin;

endmodule

// File: tb/tb_memarbiter.sv
// Bench for memarbiter: transaction-timeline reference model, per-cycle compare, directed and random traffic.
module tb_memarbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1, busy, mem_write_en, mem_read_en;
  logic [DW-1:0] rdata0, rdata1, mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic [AW-1:0] mem_address;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memarbiter #(.addresswidth(AW), .width(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  // Falling-edge single-port memory stand-in (word addressed, 256 words).
  logic [DW-1:0] mem [256];
  always @(negedge clk) begin
    if (mem_write_en === 1'b1) mem[mem_address[9:2]] <= mem_data_in;
    if (mem_read_en === 1'b1) mem_data_out <= mem[mem_address[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Timeline view: a grant decided at edge d drives memory in the following cycle,
  // is acked after edge d+1, and the next decision may happen at edge d+2 with
  // the acked port excluded at exactly that edge.
  logic [DW-1:0] ref_mem [256];
  int            ecnt = 0;
  int            m_next_dec = 0;
  int            m_excl = -1;
  int            m_ack_edge = -1;
  bit            m_pend = 0;
  bit            m_last = 1;
  int            m_port = 0;
  bit            m_we = 0;
  bit            m_mis = 0;
  logic [AW-1:0] m_addr = '0;
  logic          e_ack0, e_ack1, e_err0, e_err1, e_wen, e_ren, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, e_rd0, e_rd1;

  task automatic model_step();
    logic [1:0]    elig;
    int            p;
    logic [AW-1:0] a;
    ecnt++;
    e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_wen = 0; e_ren = 0;
    if (reset) begin
      m_pend = 0; m_last = 1; m_excl = -1; m_next_dec = 0;
      e_busy = 0; e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      e_busy = 0;
      if (m_pend && ecnt == m_ack_edge) begin
        m_pend = 0;
        e_busy = 1;
        if (m_port == 0) begin
          e_ack0 = 1; e_err0 = m_mis;
          if (!m_we && !m_mis) e_rd0 = ref_mem[m_addr[9:2]];
        end else begin
          e_ack1 = 1; e_err1 = m_mis;
          if (!m_we && !m_mis) e_rd1 = ref_mem[m_addr[9:2]];
        end
      end
      if (ecnt >= m_next_dec) begin
        elig = {req1, req0};
        if (ecnt == m_next_dec && m_excl >= 0) elig[m_excl] = 1'b0;
        if (elig != 2'b00) begin
          if (elig == 2'b11) p = m_last ? 0 : 1;
          else p = elig[1] ? 1 : 0;
          a = (p == 1) ? addr1 : addr0;
          m_last = (p == 1);
          m_port = p;
          m_we = (p == 1) ? we1 : we0;
          m_mis = (a[1:0] != 2'b00);
          m_addr = a;
          m_pend = 1;
          m_ack_edge = ecnt + 1;
          m_next_dec = ecnt + 2;
          m_excl = p;
          e_busy = 1;
          e_addr = a;
          e_din = (p == 1) ? wdata1 : wdata0;
          if (!m_mis) begin
            e_wen = m_we;
            e_ren = !m_we;
            if (m_we) ref_mem[a[9:2]] = e_din;
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk1("ack0", ack0, e_ack0);
      chk1("ack1", ack1, e_ack1);
      chk1("err0", err0, e_err0);
      chk1("err1", err1, e_err1);
      chk1("busy", busy, e_busy);
      chk1("mem_write_en", mem_write_en, e_wen);
      chk1("mem_read_en", mem_read_en, e_ren);
      chk("rdata0", rdata0, e_rd0);
      chk("rdata1", rdata1, e_rd1);
      if (e_wen || e_ren) chk("mem_address", mem_address, e_addr);
      if (e_wen) chk("mem_data_in", mem_data_in, e_din);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_reset();
    reset = 1; req0 = 0; req1 = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic xact(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat, output int wen_cnt, output logic [AW-1:0] wen_addr,
                      output logic err, output logic [DW-1:0] rd);
    lat = -1; wen_cnt = 0; wen_addr = '0; err = 1'bx; rd = 'x;
    if (port == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_write_en === 1'b1) begin wen_cnt++; wen_addr = mem_address; end
      if ((port == 0 && ack0 === 1'b1) || (port == 1 && ack1 === 1'b1)) begin
        lat = n;
        err = (port == 0) ? err0 : err1;
        rd  = (port == 0) ? rdata0 : rdata1;
        break;
      end
    end
    @(posedge clk); #1;
    if (port == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic both_reads(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int n0 = -1;
    int n1 = -1;
    req0 = 1; we0 = 0; addr0 = a0; req1 = 1; we1 = 0; addr1 = a1;
    for (int n = 1; n <= 20 && (n0 < 0 || n1 < 0); n++) begin
      @(negedge clk);
      if (ack0 === 1'b1 && n0 < 0) begin n0 = n; chk({tag, "_rdata0"}, rdata0, d0); end
      if (ack1 === 1'b1 && n1 < 0) begin n1 = n; chk({tag, "_rdata1"}, rdata1, d1); end
      @(posedge clk); #1;
      if (n0 == n) req0 = 0;
      if (n1 == n) req1 = 0;
    end
    req0 = 0; req1 = 0;
    chk({tag, "_ack0_cycle"}, n0, 3);
    chk({tag, "_ack1_cycle"}, n1, 5);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = {22'b0, 8'($urandom_range(0, 31)), 2'b00};
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int            lat, wcnt, nack, last_n, port, overlap;
    logic [AW-1:0] waddr;
    logic          e;
    logic [DW-1:0] rd;
    logic          s0, s1;

    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_wen", mem_write_en, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);

    // write then read back through port 0
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, wcnt, waddr, e, rd);
    chk("wr_ack_cycle", lat, 3);
    chk("wr_wen_cycles", wcnt, 1);
    chk("wr_wen_addr", waddr, 32'h10);
    chk1("wr_err0", e, 1'b0);
    xact(0, 1'b0, 32'h10, 32'h0, lat, wcnt, waddr, e, rd);
    chk("rd_ack_cycle", lat, 3);
    chk("rd_rdata0", rd, 32'hDEADBEEF);

    // simultaneous requests after reset: port 0 first, port 1 back-to-back
    pulse_reset();
    both_reads("tie", 32'h20, 32'h24, 32'hA500_0008, 32'hA500_0009);

    // both ports continuously requesting: strict alternation every 2 cycles
    req0 = 1; we0 = 0; addr0 = 32'h44;
    req1 = 1; we1 = 1; addr1 = 32'h44; wdata1 = 32'h1234_5678;
    nack = 0; last_n = 0; overlap = 0;
    for (int n = 1; n <= 40 && nack < 6; n++) begin
      @(negedge clk);
      if (ack0 === 1'b1 && ack1 === 1'b1) overlap++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        nack++;
        port = (ack1 === 1'b1) ? 1 : 0;
        chk($sformatf("alt_port%0d", nack), port, (nack - 1) % 2);
        if (nack > 1) chk($sformatf("alt_gap%0d", nack), n - last_n, 2);
        if (nack == 1) chk("alt_first_rdata0", rdata0, 32'hA500_0011);
        if (nack == 5) chk("alt_fifth_rdata0", rdata0, 32'h1234_5678);
        last_n = n;
        @(posedge clk); #1;
        if (nack == 5) req0 = 0;
        if (nack == 6) req1 = 0;
      end else begin
        @(posedge clk); #1;
      end
    end
    req0 = 0; req1 = 0;
    chk("alt_count", nack, 6);
    chk("alt_overlap", overlap, 0);
    repeat (2) @(posedge clk);
    #1;

    // misaligned write on port 1: error, no memory write, word untouched
    xact(1, 1'b1, 32'h13, 32'hCAFEF00D, lat, wcnt, waddr, e, rd);
    chk("mis_ack_cycle", lat, 3);
    chk1("mis_err1", e, 1'b1);
    chk("mis_wen_cycles", wcnt, 0);
    xact(0, 1'b0, 32'h10, 32'h0, lat, wcnt, waddr, e, rd);
    chk("mis_readback", rd, 32'hDEADBEEF);

    // reset during the ACCESS cycle of a port-1 read
    req1 = 1; we1 = 0; addr1 = 32'h20;
    @(posedge clk); #1;
    reset = 1; req1 = 0;
    @(posedge clk); #1;
    reset = 0;
    chk1("rstacc_ack1", ack1, 1'b0);
    chk1("rstacc_busy", busy, 1'b0);
    both_reads("rstacc", 32'h30, 32'h34, 32'hA500_000C, 32'hA500_000D);

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s0 = ack0; s1 = ack1;
      @(posedge clk); #1;
      if (reset) begin
        reset = 0;
      end else if ($urandom_range(0, 199) == 0) begin
        reset = 1; req0 = 0; req1 = 0;
      end else begin
        if (!req0 || s0 === 1'b1) begin
          if ($urandom_range(0, 2) != 0) begin
            req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = rand_addr(); wdata0 = $urandom();
          end else begin
            req0 = 0;
          end
        end
        if (!req1 || s1 === 1'b1) begin
          if ($urandom_range(0, 2) != 0) begin
            req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = rand_addr(); wdata1 = $urandom();
          end else begin
            req1 = 0;
          end
        end
      end
    end
    reset = 0;
    for (int c = 0; c < 60 && (req0 || req1 || busy === 1'b1); c++) begin
      @(negedge clk);
      s0 = ack0; s1 = ack1;
      @(posedge clk); #1;
      if (s0 === 1'b1) req0 = 0;
      if (s1 === 1'b1) req1 = 0;
    end
    chk1("drain_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
